// File: rtl/modem_axi_master.sv
// AXI4-Lite single-beat master: turns a command/response handshake into one AXI read or write
// at a time, with a per-transaction watchdog that aborts transactions to slaves that hang.
module modem_axi_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 13,
    parameter int C_TIMEOUT          = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_write_i,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb_i,
    output logic                            rsp_valid_o,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]                      rsp_resp_o,
    output logic                            rsp_timeout_o,
    output logic                            busy_o,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_e;

    localparam logic [15:0] TIMEOUT_CNT = 16'(C_TIMEOUT);
    localparam int          SW          = C_M_AXI_DATA_WIDTH / 8;

    state_e                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]                   wstrb_q, wstrb_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            arvalid_q, arvalid_d;
    logic                            bready_q, bready_d;
    logic                            rready_q, rready_d;
    logic [15:0]                     count_q, count_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic                            rsp_timeout_q, rsp_timeout_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                      rsp_resp_q, rsp_resp_d;
    logic                            complete;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        count_d       = count_q + 16'd1;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        complete      = 1'b0;

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (cmd_valid_i) begin
                    addr_d    = cmd_addr_i;
                    wdata_d   = cmd_wdata_i;
                    wstrb_d   = cmd_wstrb_i;
                    awvalid_d = cmd_write_i;
                    wvalid_d  = cmd_write_i;
                    state_d   = cmd_write_i ? WADDR : RADDR;
                end
            end
            WADDR: begin
                // A low VALID here doubles as the "channel done" flag for AW and W.
                awvalid_d = awvalid_q & ~M_AXI_AWREADY;
                wvalid_d  = wvalid_q & ~M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) state_d = WRESP;
            end
            WRESP: begin
                if (M_AXI_BVALID) begin
                    complete    = 1'b1;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = M_AXI_BRESP;
                end
            end
            RADDR: begin
                if (M_AXI_ARREADY) state_d = RDATA;
            end
            RDATA: begin
                if (M_AXI_RVALID) begin
                    complete    = 1'b1;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completing B/R handshake in the deadline cycle still wins over the abort.
        if (state_q != IDLE && count_q == TIMEOUT_CNT && !complete) begin
            state_d       = IDLE;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
        end

        arvalid_d = (state_d == RADDR);
        bready_d  = (state_d == WRESP);
        rready_d  = (state_d == RDATA);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            count_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            count_q       <= count_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_resp_o    = rsp_resp_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_modem_axi_master.sv
// Bench for modem_axi_master: directed and random transactions against a cycle-timing model
// of the command/response and AXI channels, with the watchdog shortened to 16 cycles.
module tb_modem_axi_master;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i, cmd_write_i;
    logic        cmd_ready_o;
    logic [12:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_wstrb_i;
    logic        rsp_valid_o, rsp_timeout_o, busy_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_resp_o;
    logic [12:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    modem_axi_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(13),
        .C_TIMEOUT(TMO)
    ) dut (
        .M_AXI_ACLK(clk),       .M_AXI_ARESETN(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i),   .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
        .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata),   .M_AXI_WSTRB(wstrb),   .M_AXI_WVALID(wvalid),   .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp),   .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata),   .M_AXI_RRESP(rresp),   .M_AXI_RVALID(rvalid),   .M_AXI_RREADY(rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    endtask

    task automatic check_rsp(input bit to, input logic [1:0] resp, input logic [31:0] data);
        check("rsp_valid", rsp_valid_o, 1);
        check("rsp_timeout", rsp_timeout_o, to);
        check("rsp_resp", rsp_resp_o, to ? 2'b10 : resp);
        check("rsp_rdata", rsp_rdata_o, to ? 32'h0 : data);
        check("busy_at_rsp", busy_o, 0);
        check("ready_at_rsp", cmd_ready_o, 1);
        check("valids_at_rsp", {awvalid, wvalid, arvalid, bready, rready}, 0);
    endtask

    // t counts cycles from the VALID rise; a channel's READY is offered from its delay onward.
    task automatic run_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_d, input int w_d, input int b_d, input logic [1:0] br);
        int t_done, t_b, end_t;
        bit to;
        t_done = (aw_d > w_d) ? aw_d : w_d;
        t_b    = t_done + 1 + b_d;
        to     = (t_b > TMO);
        end_t  = to ? TMO : t_b;
        cmd_valid_i = 1; cmd_write_i = 1; cmd_addr_i = a; cmd_wdata_i = d; cmd_wstrb_i = s;
        check("wr_cmd_ready", cmd_ready_o, 1);
        step();
        cmd_valid_i = 0; cmd_addr_i = 13'($urandom); cmd_wdata_i = $urandom; cmd_wstrb_i = 4'($urandom);
        for (int t = 0; t <= end_t; t++) begin
            check("awvalid", awvalid, (t <= aw_d));
            check("wvalid", wvalid, (t <= w_d));
            check("bready", bready, (t > t_done));
            check("ar_r_idle", {arvalid, rready}, 0);
            check("wr_busy", {busy_o, cmd_ready_o, rsp_valid_o}, 3'b100);
            if (t <= aw_d) check("awaddr", awaddr, a);
            if (t <= w_d) check("wdata_wstrb", {wdata, wstrb}, {d, s});
            awready = (t >= aw_d);
            wready  = (t >= w_d);
            bvalid  = (t == t_b);
            bresp   = (t == t_b) ? br : 2'($urandom);
            step();
        end
        slave_idle();
        check_rsp(to, br, 32'h0);
        step();
        check("wr_rsp_pulse_end", rsp_valid_o, 0);
    endtask

    task automatic run_read(input logic [12:0] a, input int ar_d, input int r_d,
                            input logic [31:0] d, input logic [1:0] rr);
        int t_r, end_t;
        bit to;
        t_r   = ar_d + 1 + r_d;
        to    = (t_r > TMO);
        end_t = to ? TMO : t_r;
        cmd_valid_i = 1; cmd_write_i = 0; cmd_addr_i = a; cmd_wdata_i = $urandom;
        check("rd_cmd_ready", cmd_ready_o, 1);
        step();
        cmd_valid_i = 0; cmd_addr_i = 13'($urandom);
        for (int t = 0; t <= end_t; t++) begin
            check("arvalid", arvalid, (t <= ar_d));
            check("rready", rready, (t > ar_d));
            check("aw_w_b_idle", {awvalid, wvalid, bready}, 0);
            check("rd_busy", {busy_o, cmd_ready_o, rsp_valid_o}, 3'b100);
            if (t <= ar_d) check("araddr", araddr, a);
            arready = (t >= ar_d);
            rvalid  = (t == t_r);
            rdata   = (t == t_r) ? d : $urandom;
            rresp   = (t == t_r) ? rr : 2'($urandom);
            step();
        end
        slave_idle();
        check_rsp(to, rr, d);
        step();
        check("rd_rsp_pulse_end", rsp_valid_o, 0);
    endtask

    initial begin
        bit          wr;
        int          d1, d2, d3;
        logic [31:0] rd;
        rst_n = 1; cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = 0; cmd_wdata_i = 0; cmd_wstrb_i = 0;
        slave_idle();
        #2 rst_n = 0;
        #1;
        check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check("rst_rsp", {rsp_valid_o, rsp_timeout_o, busy_o, rsp_resp_o}, 0);
        check("rst_rdata", rsp_rdata_o, 0);
        check("rst_addr_data", {awaddr, wdata, wstrb}, 0);
        check("rst_prot", {awprot, arprot}, 0);
        check("rst_cmd_ready", cmd_ready_o, 1);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1;
        step();

        // Zero-wait write: VALIDs at cycle 1 only, BREADY at 2, response at 3.
        run_write(13'h804, 32'h0000_0028, 4'hF, 0, 0, 0, 2'b00);
        // Split write: WREADY three cycles after AWREADY.
        run_write(13'h123, 32'hDEAD_BEEF, 4'h5, 0, 3, 1, 2'b00);
        // Read with two wait cycles before RVALID.
        run_read(13'h80c, 0, 2, 32'h0000_03FC, 2'b00);
        // Silent slave: abort 17 cycles after the VALID rise.
        run_read(13'h0A0, 100, 0, 32'h1234_5678, 2'b00);
        run_write(13'h0B0, 32'hCAFE_0001, 4'h3, 100, 2, 0, 2'b00);
        // BVALID lands exactly on the deadline cycle: normal response wins.
        run_write(13'h0C4, 32'h0000_0001, 4'hF, 0, 0, TMO - 1, 2'b01);
        // RVALID on the deadline cycle.
        run_read(13'h0C8, 1, TMO - 2, 32'hA5A5_5A5A, 2'b11);

        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            d1 = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
            d2 = $urandom_range(0, 4);
            d3 = $urandom_range(0, 5);
            rd = $urandom;
            if (wr) run_write(13'($urandom), $urandom, 4'($urandom), d1, d2, d3, 2'($urandom));
            else    run_read(13'($urandom), d1, d3, rd, 2'($urandom));
        end

        // Back-to-back: cmd_valid_i held high, the read is accepted on the write's response cycle.
        awready = 1; wready = 1; arready = 1;
        cmd_valid_i = 1; cmd_write_i = 1; cmd_addr_i = 13'h010; cmd_wdata_i = 32'h0000_00AA; cmd_wstrb_i = 4'hF;
        check("b2b_accept_wr", cmd_ready_o, 1);
        step();
        check("b2b_awvalid", {awvalid, wvalid, cmd_ready_o}, 3'b110);
        step();
        check("b2b_bready", {bready, cmd_ready_o}, 2'b10);
        bvalid = 1; bresp = 2'b00;
        step();
        bvalid = 0;
        check_rsp(0, 2'b00, 32'h0);
        cmd_write_i = 0; cmd_addr_i = 13'h014;
        step();
        cmd_valid_i = 0;
        check("b2b_arvalid", {arvalid, rsp_valid_o, busy_o}, 3'b101);
        check("b2b_araddr", araddr, 13'h014);
        step();
        check("b2b_rready", rready, 1);
        rvalid = 1; rdata = 32'h0000_0BEE; rresp = 2'b00;
        step();
        slave_idle();
        check_rsp(0, 2'b00, 32'h0000_0BEE);
        step();
        check("b2b_pulse_end", rsp_valid_o, 0);

        // Reset in the middle of a read: ARVALID must fall without waiting for a clock edge.
        cmd_valid_i = 1; cmd_write_i = 0; cmd_addr_i = 13'h1F0;
        step();
        cmd_valid_i = 0;
        check("midrst_arvalid_before", arvalid, 1);
        step(); step();
        #2 rst_n = 0;
        #1;
        check("midrst_arvalid_async", {arvalid, busy_o}, 0);
        check("midrst_ready", cmd_ready_o, 1);
        #1 rst_n = 1;
        step();
        check("midrst_no_rsp", {rsp_valid_o, arvalid, busy_o, cmd_ready_o}, 4'b0001);
        step();
        check("midrst_no_rsp2", rsp_valid_o, 0);
        run_write(13'h1F4, 32'h0F0F_0F0F, 4'hC, 1, 0, 0, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
